// File: rtl/fifo_write_arbiter.sv
// Purpose: round-robin arbiter sharing one Fifo_buffer write port among NUM_REQ producers, bursts up to BURST_LEN beats.
// Latency: req at cycle t with port idle -> gnt at t+1 -> first write at t+1 (one idle arbitration cycle between grants).
// Backpressure: fifo_full stalls the owner (no write, grant held, no timeout); non-owners wait for their grant.
//
// Ports:
//   clk, rst          clock (posedge) and synchronous active-high reset
//   req, last         per-requester beat valid / end-of-burst marker
//   din               requester i data at slice [i*W +: W], W = PAR_WRITE*DATA_WIDTH
//   fifo_full         full flag from the Fifo_buffer
//   gnt               registered one-hot owner, zero while idle
//   ack               per-requester beat-written strobe (combinational)
//   fifo_wen/fifo_din write enable and owner's data toward the Fifo_buffer
//
// Optional feature: define FIFO_ARB_PRIO_EN to make requester 0 win every arbitration it takes part in.

module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 1,
    parameter int BURST_LEN  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ-1:0]                    last,
    input  logic [NUM_REQ*PAR_WRITE*DATA_WIDTH-1:0] din,
    input  logic                                  fifo_full,
    output logic [NUM_REQ-1:0]                    gnt,
    output logic [NUM_REQ-1:0]                    ack,
    output logic                                  fifo_wen,
    output logic [PAR_WRITE*DATA_WIDTH-1:0]       fifo_din
);

    localparam int W  = PAR_WRITE * DATA_WIDTH;
    localparam int OW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr_ptr;     // index of the most recent round-robin winner
    logic [BW-1:0]   beat_cnt;

    logic [W-1:0]    din_arr [NUM_REQ];
    logic            accept;
    logic            arb_any;
    logic            arb_found;
    logic [OW-1:0]   arb_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            din_arr[i] = din[i*W +: W];
        end
    end

    // Reset gates the write so nothing lands in the FIFO during the reset cycle.
    assign accept   = (state == BURST) && req[owner] && !fifo_full && !rst;
    assign fifo_wen = accept;
    assign fifo_din = din_arr[owner];

    always_comb begin
        ack        = '0;
        ack[owner] = accept;
    end

    // Scan rr_ptr+1, rr_ptr+2, ... so the last winner is considered last.
    always_comb begin
        arb_any   = |req;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!arb_found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_idx   = OW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
`ifdef FIFO_ARB_PRIO_EN
        if (req[0]) begin
            arb_idx = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= OW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        state    <= BURST;
                        owner    <= arb_idx;
                        gnt      <= NUM_REQ'(1) << arb_idx;
                        beat_cnt <= '0;
`ifdef FIFO_ARB_PRIO_EN
                        // A priority win by requester 0 leaves the rotation untouched.
                        if (arb_idx != '0) begin
                            rr_ptr <= arb_idx;
                        end
`else
                        rr_ptr   <= arb_idx;
`endif
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        // Owner withdrew: release the port.
                        state <= IDLE;
                        gnt   <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last[owner] || (beat_cnt == BW'(BURST_LEN - 1))) begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule
